// File: rtl/vector_exec_sequencer_pkg.sv
// Shared definitions for the vector execution sequencer: FSM states, op codes,
// SEW encodings and issue_cfg field offsets as packed by the decode stage.
package vector_exec_sequencer_pkg;

    localparam int MAX_VLEN = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    localparam logic [2:0] OP_ADDSUB = 3'b000;
    localparam logic [2:0] OP_LOGIC  = 3'b001;
    localparam logic [2:0] OP_NONE   = 3'b010;  // unsupported; also "no unit enabled"
    localparam logic [2:0] OP_MUL    = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;
    localparam logic [2:0] OP_CMP    = 3'b101;
    localparam logic [2:0] OP_ACCUM  = 3'b110;
    localparam logic [2:0] OP_MAC    = 3'b111;

    // One-hot SEW, bit index = log2(element width)
    localparam logic [6:0] SEW_8  = 7'b0001000;
    localparam logic [6:0] SEW_16 = 7'b0010000;
    localparam logic [6:0] SEW_32 = 7'b0100000;

    localparam int CFG_SHIFT_OP_LSB = 0;   // 2 bits
    localparam int CFG_ACCUM_OP_BIT = 2;
    localparam int CFG_CMP_OP_LSB   = 3;   // 3 bits
    localparam int CFG_BITWISE_LSB  = 6;   // 5 bits
    localparam int CFG_REV_SUB_BIT  = 11;
    localparam int CFG_MUL_HIGH_BIT = 12;
    localparam int CFG_MUL_LOW_BIT  = 13;
    localparam int CFG_SIGNED_BIT   = 14;
    localparam int CFG_CTRL_BIT     = 15;

    function automatic logic op_supported(input logic [2:0] op);
        return op != OP_NONE;
    endfunction

    function automatic logic sew_supported(input logic [6:0] sew);
        return (sew == SEW_8) || (sew == SEW_16) || (sew == SEW_32);
    endfunction

endpackage

// File: rtl/vector_exec_sequencer_if.sv
// Bundle of the decode-side issue handshake, execution-unit drive/return and
// writeback handshake; slave is the sequencer's view, master the surrounding logic.
interface vector_exec_sequencer_if
    import vector_exec_sequencer_pkg::*;
#(
    parameter int VLEN = MAX_VLEN
);
    logic            issue_valid;
    logic            issue_ready;
    logic [2:0]      issue_op;
    logic [VLEN-1:0] issue_data_1;
    logic [VLEN-1:0] issue_data_2;
    logic [VLEN-1:0] issue_data_3;
    logic [6:0]      issue_sew;
    logic [15:0]     issue_cfg;

    logic [VLEN-1:0] eu_data_1;
    logic [VLEN-1:0] eu_data_2;
    logic [VLEN-1:0] eu_data_3;
    logic [2:0]      eu_op;
    logic [6:0]      eu_sew;
    logic [15:0]     eu_cfg;
    logic [VLEN-1:0] eu_result;
    logic            eu_done;

    logic            res_valid;
    logic            res_ready;
    logic [VLEN-1:0] res_data;
    logic            res_err;

    logic            busy;

    modport slave (
        input  issue_valid, issue_op, issue_data_1, issue_data_2, issue_data_3,
               issue_sew, issue_cfg, eu_result, eu_done, res_ready,
        output issue_ready, eu_data_1, eu_data_2, eu_data_3, eu_op, eu_sew, eu_cfg,
               res_valid, res_data, res_err, busy
    );

    modport master (
        output issue_valid, issue_op, issue_data_1, issue_data_2, issue_data_3,
               issue_sew, issue_cfg, eu_result, eu_done, res_ready,
        input  issue_ready, eu_data_1, eu_data_2, eu_data_3, eu_op, eu_sew, eu_cfg,
               res_valid, res_data, res_err, busy
    );

endinterface

// File: rtl/vector_exec_sequencer.sv
// Runs one vector op at a time: latch operands, drive the execution unit, capture result or error.
// Latency: 1 cycle + EU time (bounded by TIMEOUT); res_ready low holds the result and blocks issue.
module vector_exec_sequencer
    import vector_exec_sequencer_pkg::*;
#(
    parameter int VLEN    = MAX_VLEN,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_exec_sequencer_if.slave bus
);
    localparam int            TW     = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [TW-1:0]   timer;
    logic            issue_ok;
    logic            accept;
    logic            timed_out;
    logic            issue_ready_c;
    logic            busy_c;

    logic [VLEN-1:0] eu_data_1_q;
    logic [VLEN-1:0] eu_data_2_q;
    logic [VLEN-1:0] eu_data_3_q;
    logic [2:0]      eu_op_q;
    logic [6:0]      eu_sew_q;
    logic [15:0]     eu_cfg_q;
    logic [VLEN-1:0] res_data_q;
    logic            res_valid_q;
    logic            res_err_q;

    assign issue_ok  = op_supported(bus.issue_op) && sew_supported(bus.issue_sew);
    assign accept    = (state == ST_IDLE) && bus.issue_valid;
    assign timed_out = (timer == T_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        issue_ready_c = 1'b0;
        busy_c        = 1'b1;
        case (state)
            ST_IDLE: begin
                issue_ready_c = 1'b1;
                busy_c        = 1'b0;
                if (bus.issue_valid) begin
                    state_nxt = issue_ok ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                if (bus.eu_done || timed_out) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // eu_* only carry a live op during EXEC; outside it the unit sees OP_NONE and zero data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            eu_data_1_q <= '0;
            eu_data_2_q <= '0;
            eu_data_3_q <= '0;
            eu_op_q     <= OP_NONE;
            eu_sew_q    <= SEW_8;
            eu_cfg_q    <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        timer <= '0;
                        if (issue_ok) begin
                            eu_data_1_q <= bus.issue_data_1;
                            eu_data_2_q <= bus.issue_data_2;
                            eu_data_3_q <= bus.issue_data_3;
                            eu_op_q     <= bus.issue_op;
                            eu_sew_q    <= bus.issue_sew;
                            eu_cfg_q    <= bus.issue_cfg;
                        end else begin
                            res_data_q <= '0;
                            res_err_q  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    // done is checked before the timer so a coincident done is never flagged
                    if (bus.eu_done) begin
                        res_data_q  <= bus.eu_result;
                        res_err_q   <= 1'b0;
                        eu_op_q     <= OP_NONE;
                        eu_data_1_q <= '0;
                        eu_data_2_q <= '0;
                        eu_data_3_q <= '0;
                    end else if (timed_out) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        eu_op_q     <= OP_NONE;
                        eu_data_1_q <= '0;
                        eu_data_2_q <= '0;
                        eu_data_3_q <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            res_valid_q <= (state_nxt == ST_RESP);
        end
    end

    assign bus.issue_ready = issue_ready_c && !reset;
    assign bus.busy        = busy_c;
    assign bus.eu_data_1   = eu_data_1_q;
    assign bus.eu_data_2   = eu_data_2_q;
    assign bus.eu_data_3   = eu_data_3_q;
    assign bus.eu_op       = eu_op_q;
    assign bus.eu_sew      = eu_sew_q;
    assign bus.eu_cfg      = eu_cfg_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_err     = res_err_q;

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Bench for vector_exec_sequencer: directed table, randomized ops against a
// latency/result model, backpressure and mid-operation reset sequences.
module tb_vector_exec_sequencer;
    import vector_exec_sequencer_pkg::*;

    localparam int VL  = 32;
    localparam int TMO = 8;

    typedef struct {
        logic [2:0]    op;
        logic [6:0]    sew;
        logic [VL-1:0] d1;
        logic [VL-1:0] d2;
        logic [VL-1:0] d3;
        logic [15:0]   cfg;
        int            dly;      // EXEC cycles before done; -1 = never
        int            bp;       // cycles res_ready stays low after res_valid
        int            exp_lat;  // edges from handshake to res_valid
        logic          exp_err;
        logic [VL-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   eu_dly = 0;
    int   exec_cnt = 0;

    logic [2:0] op_pool [8];
    logic [6:0] sew_pool [8];

    vector_exec_sequencer_if #(.VLEN(VL)) bus();

    vector_exec_sequencer #(.VLEN(VL), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Lane-wise behaviour of the execution unit stand-in
    function automatic logic [VL-1:0] eu_calc(input logic [2:0] op, input logic [6:0] sew,
                                              input logic [VL-1:0] a, input logic [VL-1:0] b,
                                              input logic [VL-1:0] c);
        int            w;
        logic [63:0]   x, y, z, s, m;
        logic [VL-1:0] r;
        w = (sew == SEW_8) ? 8 : (sew == SEW_16) ? 16 : 32;
        m = (64'd1 << w) - 64'd1;
        r = '0;
        for (int l = 0; l < VL / w; l++) begin
            x = (64'(a) >> (l * w)) & m;
            y = (64'(b) >> (l * w)) & m;
            z = (64'(c) >> (l * w)) & m;
            case (op)
                OP_ADDSUB: s = x + y;
                OP_MUL:    s = x * y;
                OP_MAC:    s = x * y + z;
                default:   s = x ^ y ^ z;
            endcase
            r = r | VL'((s & m) << (l * w));
        end
        return r;
    endfunction

    always_comb begin
        bus.eu_result = eu_calc(bus.eu_op, bus.eu_sew, bus.eu_data_1, bus.eu_data_2, bus.eu_data_3);
        bus.eu_done   = (bus.eu_op != OP_NONE) && (eu_dly >= 0) && (exec_cnt == eu_dly);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) exec_cnt <= 0;
        else if (bus.eu_op == OP_NONE) exec_cnt <= 0;
        else exec_cnt <= exec_cnt + 1;
    end

    function automatic logic [15:0] cfg_pack(input logic ctrl, input logic sgn, input logic mlo,
                                             input logic mhi, input logic rev, input logic [4:0] bw,
                                             input logic [2:0] cmp, input logic acc, input logic [1:0] sh);
        logic [15:0] c;
        c = '0;
        c[CFG_CTRL_BIT]              = ctrl;
        c[CFG_SIGNED_BIT]            = sgn;
        c[CFG_MUL_LOW_BIT]           = mlo;
        c[CFG_MUL_HIGH_BIT]          = mhi;
        c[CFG_REV_SUB_BIT]           = rev;
        c[CFG_BITWISE_LSB +: 5]      = bw;
        c[CFG_CMP_OP_LSB +: 3]       = cmp;
        c[CFG_ACCUM_OP_BIT]          = acc;
        c[CFG_SHIFT_OP_LSB +: 2]     = sh;
        return c;
    endfunction

    function automatic logic [15:0] rand_cfg();
        return cfg_pack(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        5'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [6:0] sew, input logic [VL-1:0] d1,
                                input logic [VL-1:0] d2, input logic [VL-1:0] d3, input int dly,
                                input int bp, input int lat, input logic err, input logic [VL-1:0] data);
        vec_t v;
        v.op = op; v.sew = sew; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.cfg = rand_cfg();
        v.dly = dly; v.bp = bp; v.exp_lat = lat; v.exp_err = err; v.exp_data = data;
        return v;
    endfunction

    // Expected outcome from the operation rules: reject, complete, or time out
    function automatic vec_t ref_model(input vec_t vin);
        vec_t v;
        v = vin;
        if (v.op == OP_NONE || !(v.sew == SEW_8 || v.sew == SEW_16 || v.sew == SEW_32)) begin
            v.exp_lat = 0; v.exp_err = 1'b1; v.exp_data = '0;
        end else if (v.dly >= 0 && v.dly < TMO) begin
            v.exp_lat = v.dly + 1; v.exp_err = 1'b0; v.exp_data = eu_calc(v.op, v.sew, v.d1, v.d2, v.d3);
        end else begin
            v.exp_lat = TMO; v.exp_err = 1'b1; v.exp_data = '0;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk($sformatf("%s issue_ready", tag), 64'(bus.issue_ready), 64'd0);
        chk($sformatf("%s busy", tag), 64'(bus.busy), 64'd0);
        chk($sformatf("%s res_valid", tag), 64'(bus.res_valid), 64'd0);
        chk($sformatf("%s res_err", tag), 64'(bus.res_err), 64'd0);
        chk($sformatf("%s res_data", tag), 64'(bus.res_data), 64'd0);
        chk($sformatf("%s eu_op", tag), 64'(bus.eu_op), 64'(OP_NONE));
        chk($sformatf("%s eu_sew", tag), 64'(bus.eu_sew), 64'(7'b0001000));
        chk($sformatf("%s eu_cfg", tag), 64'(bus.eu_cfg), 64'd0);
        chk($sformatf("%s eu_data", tag), 64'(bus.eu_data_1 | bus.eu_data_2 | bus.eu_data_3), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int            lat;
        bit            got, stable, busy_ok, hold_ok;
        logic [VL-1:0] held;
        @(negedge clk);
        eu_dly           = v.dly;
        bus.issue_op     = v.op;
        bus.issue_sew    = v.sew;
        bus.issue_data_1 = v.d1;
        bus.issue_data_2 = v.d2;
        bus.issue_data_3 = v.d3;
        bus.issue_cfg    = v.cfg;
        bus.issue_valid  = 1'b1;
        bus.res_ready    = 1'b0;
        chk($sformatf("v%0d issue_ready", idx), 64'(bus.issue_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.issue_valid  = 1'b0;
        bus.issue_op     = 3'($urandom);
        bus.issue_sew    = 7'($urandom);
        bus.issue_data_1 = $urandom;
        bus.issue_data_2 = $urandom;
        bus.issue_data_3 = $urandom;
        bus.issue_cfg    = 16'($urandom);
        lat = 0; got = 0; stable = 1; busy_ok = 1;
        while (!got && lat <= 40) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                got = 1;
            end else begin
                if (bus.eu_op !== v.op || bus.eu_sew !== v.sew || bus.eu_cfg !== v.cfg ||
                    bus.eu_data_1 !== v.d1 || bus.eu_data_2 !== v.d2 || bus.eu_data_3 !== v.d3)
                    stable = 0;
                if (bus.busy !== 1'b1 || bus.issue_ready !== 1'b0) busy_ok = 0;
                @(posedge clk);
                lat++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL v%0d res_valid_wait actual=none required=latency %0d", idx, v.exp_lat);
            bus.res_ready = 1'b1;
            repeat (2) @(posedge clk);
            bus.res_ready = 1'b0;
        end else begin
            chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
            chk($sformatf("v%0d res_err", idx), 64'(bus.res_err), 64'(v.exp_err));
            chk($sformatf("v%0d res_data", idx), 64'(bus.res_data), 64'(v.exp_data));
            chk($sformatf("v%0d eu_stable", idx), 64'(stable), 64'd1);
            chk($sformatf("v%0d busy_in_flight", idx), 64'(busy_ok), 64'd1);
            chk($sformatf("v%0d eu_op_in_resp", idx), 64'(bus.eu_op), 64'(OP_NONE));
            held = bus.res_data;
            hold_ok = 1;
            for (int i = 0; i < v.bp; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.res_valid !== 1'b1 || bus.res_data !== held ||
                    bus.res_err !== v.exp_err || bus.issue_ready !== 1'b0)
                    hold_ok = 0;
            end
            if (v.bp > 0) chk($sformatf("v%0d backpressure_hold", idx), 64'(hold_ok), 64'd1);
            bus.res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d release", idx), 64'({bus.res_valid, bus.issue_ready}), 64'(2'b01));
            bus.res_ready = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        vec_t rv;
        bit   quiet_ok;

        op_pool  = '{OP_ADDSUB, OP_LOGIC, OP_NONE, OP_MUL, OP_SHIFT, OP_CMP, OP_ACCUM, OP_MAC};
        sew_pool = '{SEW_8, SEW_16, SEW_32, SEW_8, SEW_16, SEW_32, 7'b1000000, 7'b0000110};

        bus.issue_valid  = 1'b0;
        bus.issue_op     = OP_NONE;
        bus.issue_sew    = SEW_8;
        bus.issue_data_1 = '0;
        bus.issue_data_2 = '0;
        bus.issue_data_3 = '0;
        bus.issue_cfg    = '0;
        bus.res_ready    = 1'b0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset issue_ready", 64'(bus.issue_ready), 64'd1);

        tbl[0]  = mk(OP_ADDSUB, SEW_8,  32'h05050505, 32'h03030303, 32'h0,        0, 0, 1, 1'b0, 32'h08080808);
        tbl[1]  = mk(OP_MUL,    SEW_32, 32'h00000007, 32'h00000006, 32'h0,        5, 0, 6, 1'b0, 32'h0000002A);
        tbl[2]  = mk(OP_MAC,    SEW_32, 32'h12345678, 32'h9ABCDEF0, 32'h1,       -1, 0, 8, 1'b1, 32'h0);
        tbl[3]  = mk(OP_NONE,   SEW_8,  32'h11111111, 32'h22222222, 32'h0,        0, 0, 0, 1'b1, 32'h0);
        tbl[4]  = mk(OP_LOGIC,  SEW_16, 32'h12345678, 32'h0F0F0F0F, 32'h1,        2, 10, 3, 1'b0, 32'h1D3B5976);
        tbl[5]  = mk(OP_LOGIC,  SEW_16, 32'hAAAA5555, 32'hFFFF0000, 32'h0,        7, 0, 8, 1'b0, 32'h55555555);
        tbl[6]  = mk(OP_ADDSUB, SEW_32, 32'h00000001, 32'h00000002, 32'h0,        8, 0, 8, 1'b1, 32'h0);
        tbl[7]  = mk(OP_ADDSUB, 7'b0000011, 32'h1, 32'h1, 32'h0,                  0, 0, 0, 1'b1, 32'h0);
        tbl[8]  = mk(OP_ADDSUB, 7'b1000000, 32'h1, 32'h1, 32'h0,                  0, 2, 0, 1'b1, 32'h0);
        tbl[9]  = mk(OP_ADDSUB, SEW_16, 32'hFFFF0001, 32'h00010001, 32'h0,        1, 0, 2, 1'b0, 32'h00000002);
        tbl[10] = mk(OP_MAC,    SEW_8,  32'h02030405, 32'h10101010, 32'h01010101, 3, 1, 4, 1'b0, 32'h21314151);
        tbl[11] = mk(OP_ADDSUB, SEW_32, 32'hFFFFFFFF, 32'h00000001, 32'h0,        0, 0, 1, 1'b0, 32'h0);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        for (int i = 0; i < 40; i++) begin
            rv = mk(op_pool[$urandom_range(0, 7)], sew_pool[$urandom_range(0, 7)],
                    $urandom, $urandom, $urandom, int'($urandom_range(0, 11)) - 1,
                    int'($urandom_range(0, 3)), 0, 1'b0, '0);
            rv = ref_model(rv);
            run_vec(rv, 100 + i);
        end

        // Reset in the middle of a multiply that never completes
        @(negedge clk);
        eu_dly           = -1;
        bus.issue_op     = OP_MUL;
        bus.issue_sew    = SEW_32;
        bus.issue_data_1 = 32'hDEADBEEF;
        bus.issue_data_2 = 32'h00000003;
        bus.issue_data_3 = 32'h0;
        bus.issue_cfg    = 16'hFFFF;
        bus.issue_valid  = 1'b1;
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk_reset_vals("mid_exec");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet_ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.issue_ready !== 1'b1) quiet_ok = 0;
        end
        chk("after_reset no_stale_response", 64'(quiet_ok), 64'd1);
        run_vec(tbl[0], 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_exec_sequencer.md
VECTOR_EXEC_SEQUENCER -- requirements
Module: vector_exec_sequencer

Interface
REQ-001 Parameters: VLEN, default `MAX_VLEN, operand/result width; TIMEOUT, default 64, maximum cycles in EXEC before abort.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 issue_valid / issue_ready  in / out  1 / 1  decode-side handshake; transfer when both are high.
REQ-005 issue_op  in  3  execution_op code; 3'b010 is unsupported.
REQ-006 issue_data_1/2/3  in  VLEN each  operands.
REQ-007 issue_sew  in  7  one-hot SEW: 8, 16 or 32.
REQ-008 issue_cfg  in  16  packed {Ctrl, signed_mode, mul_low, mul_high, reverse_sub_inst, bitwise_op[4:0], cmp_op, accum_op, shift_op} minus field overlap, as packed by the decode stage.
REQ-009 eu_data_1/2/3, eu_op, eu_sew, eu_cfg  out  VLEN/3/7/16  registered drive to the execution unit.
REQ-010 eu_result / eu_done  in  VLEN / 1  execution unit result and done.
REQ-011 res_valid / res_ready  out / in  1 / 1  writeback handshake.
REQ-012 res_data  out  VLEN  captured result.
REQ-013 res_err  out  1  qualifies res_data: timeout or unsupported op.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, RESP.
REQ-016 IDLE: issue_ready=1; on handshake, latch operands, op, sew and cfg into eu_* registers; clear timer; go to EXEC.
REQ-017 Unsupported op (3'b010) or non-one-hot/unsupported sew at handshake: skip EXEC, go to RESP with res_data=0 and res_err=1.
REQ-018 When not in EXEC, eu_op = 3'b010 (no unit enabled) and eu_data_* = 0.
REQ-019 eu_* outputs stay constant for the whole EXEC residency.
REQ-020 EXEC: eu_done sampled from the first EXEC cycle; on eu_done=1, capture eu_result into res_data, res_err=0, go to RESP.
REQ-021 Minimum latency: handshake at edge N, eu_done sampled at edge N+1, res_valid high after edge N+1, giving 1-cycle combinational ops res_valid 2 cycles after issue.
REQ-022 Multi-cycle ops (3'b011 and 3'b111) wait in EXEC until eu_done with no fixed latency.
REQ-023 Timer increments on each EXEC cycle without eu_done; when it reaches TIMEOUT-1 without done, go to RESP with res_data=0 and res_err=1.
REQ-024 If eu_done and the timeout coincide, done wins and no error is flagged.
REQ-025 RESP: res_valid=1; res_data/res_err hold until res_ready=1, then go to IDLE.
REQ-026 issue_ready=0 in EXEC and RESP; there is no issue/response overlap (single outstanding operation).
REQ-027 res_valid is registered, and res_data never changes while res_valid=1 and res_ready=0.
REQ-028 Timer width is $clog2(TIMEOUT)+1; the timer saturates and never wraps.

Reset
REQ-029 Asserting reset at any time, including mid-EXEC, forces IDLE immediately; any in-flight operation is dropped and no response is produced.
REQ-030 Reset values: issue_ready=0 while reset is asserted (1 after release), res_valid=0, res_err=0, busy=0, res_data=0, eu_data_*=0, eu_op=3'b010, eu_sew=7'b0001000, eu_cfg=0, timer=0.

Structure
REQ-031 The FSM state enum, the op-code constants and the issue_cfg field offsets belong in the shared vector_processor_defs package/header.
REQ-032 The sequencer contains no arithmetic; the single natural sub-module is vector_execution_unit, instantiated only in the test wrapper, not inside this block.

Verification
REQ-033 Test 1 (8-bit add, single cycle).
- Stimulus: issue op=000, sew=8, data_1 lanes=0x05, data_2 lanes=0x03; EU model asserts done in the same cycle.
- Required response: res_valid 2 cycles after issue, res_data lanes=0x08, res_err=0.
REQ-034 Test 2 (32-bit multiply, multi-cycle).
- Stimulus: issue op=011, sew=32; EU model asserts done after 5 cycles.
- Required response: busy=1 for 6 cycles, eu_* outputs stable throughout, res_valid on cycle 7.
REQ-035 Test 3 (timeout).
- Stimulus: TIMEOUT=8; EU model never asserts done.
- Required response: res_valid with res_err=1 and res_data=0 after 8 EXEC cycles; the next issue is accepted normally.
REQ-036 Test 4 (unsupported op).
- Stimulus: issue op=010.
- Required response: no EXEC cycle, eu_op stays 3'b010, res_err=1 one cycle after issue.
REQ-037 Test 5 (writeback backpressure).
- Stimulus: res_ready held low for 10 cycles.
- Required response: res_valid and res_data stay stable and issue_ready=0; after res_ready=1, issue_ready=1 on the next cycle.
REQ-038 Test 6 (reset mid-operation).
- Stimulus: assert reset during EXEC of a multiply.
- Required response: all outputs take reset values asynchronously; after release there is no stale res_valid.
